// File: rtl/reg_access_if.sv
// Requester-side bundle for reg_access_ctrl: clear request, writeback
// channel, operand read request and operand response handshake.
interface reg_access_if #(
   parameter int NIB_SIZE  = 4,
   parameter int WORD_SIZE = 16
);
   logic                 clear_req;
   logic                 wb_valid;
   logic                 wb_ready;
   logic [NIB_SIZE-1:0]  wb_num;
   logic [WORD_SIZE-1:0] wb_val;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [NIB_SIZE-1:0]  rd_num1;
   logic [NIB_SIZE-1:0]  rd_num2;
   logic                 op_valid;
   logic                 op_ready;
   logic [WORD_SIZE-1:0] op_val1;
   logic [WORD_SIZE-1:0] op_val2;

   modport master (
      output clear_req, wb_valid, wb_num, wb_val, rd_valid, rd_num1, rd_num2, op_ready,
      input  wb_ready, rd_ready, op_valid, op_val1, op_val2
   );

   modport slave (
      input  clear_req, wb_valid, wb_num, wb_val, rd_valid, rd_num1, rd_num2, op_ready,
      output wb_ready, rd_ready, op_valid, op_val1, op_val2
   );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register-stack access controller: serialises clear, writeback and operand
// read requests into single-cycle register-stack commands and returns the
// read operand pair through a valid/ready response.
module reg_access_ctrl #(
   parameter int NIB_SIZE       = 4,
   parameter int WORD_SIZE      = 16,
   parameter int REG_STACK_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   reg_access_if.slave          bus,
   output logic [NIB_SIZE-1:0]  rs_num1,
   output logic [NIB_SIZE-1:0]  rs_num2,
   output logic [NIB_SIZE-1:0]  rs_setnum,
   output logic [WORD_SIZE-1:0] rs_setval,
   output logic                 rs_get_enable,
   output logic                 rs_set_enable,
   output logic                 rs_reset_enable,
   input  logic [WORD_SIZE-1:0] rs_out1,
   input  logic [WORD_SIZE-1:0] rs_out2
);

   // Register numbers are forwarded unchecked, so the stack must fit the number width.
   if (REG_STACK_SIZE > (1 << NIB_SIZE)) begin : g_size_check
      $error("REG_STACK_SIZE does not fit in NIB_SIZE-bit register numbers");
   end

   typedef enum logic [2:0] {INIT, IDLE, CLEAR, SET, GET, WAIT, RESP} state_t;

   state_t               state_q;
   logic                 wait_q;
   logic [NIB_SIZE-1:0]  num1_q, num2_q, setnum_q;
   logic [WORD_SIZE-1:0] setval_q;
   logic                 get_q, set_q, rst_q;
   logic                 op_valid_q;
   logic [WORD_SIZE-1:0] op_val1_q, op_val2_q;

   // Sequencer: every stack command is a one-cycle registered pulse issued on
   // the edge that enters the command state, so enables never overlap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= INIT;
         wait_q     <= 1'b0;
         num1_q     <= '0;
         num2_q     <= '0;
         setnum_q   <= '0;
         setval_q   <= '0;
         get_q      <= 1'b0;
         set_q      <= 1'b0;
         rst_q      <= 1'b0;
         op_valid_q <= 1'b0;
         op_val1_q  <= '0;
         op_val2_q  <= '0;
      end else begin
         get_q <= 1'b0;
         set_q <= 1'b0;
         rst_q <= 1'b0;
         case (state_q)
            // First edge raises the reset pulse; the second edge drops it and opens IDLE.
            INIT: begin
               if (!rst_q) rst_q   <= 1'b1;
               else        state_q <= IDLE;
            end
            IDLE: begin
               if (bus.clear_req) begin
                  rst_q   <= 1'b1;
                  state_q <= CLEAR;
               end else if (bus.wb_valid) begin
                  setnum_q <= bus.wb_num;
                  setval_q <= bus.wb_val;
                  set_q    <= 1'b1;
                  state_q  <= SET;
               end else if (bus.rd_valid) begin
                  num1_q  <= bus.rd_num1;
                  num2_q  <= bus.rd_num2;
                  get_q   <= 1'b1;
                  state_q <= GET;
               end
            end
            CLEAR:   state_q <= IDLE;
            SET:     state_q <= IDLE;
            GET: begin
               wait_q  <= 1'b0;
               state_q <= WAIT;
            end
            // Two cycles in WAIT give the stack's registered read data time to settle.
            WAIT: begin
               if (wait_q) begin
                  op_val1_q  <= rs_out1;
                  op_val2_q  <= rs_out2;
                  op_valid_q <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  wait_q <= 1'b1;
               end
            end
            RESP: begin
               if (bus.op_ready) begin
                  op_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

   // Acceptance is only possible from IDLE; clear outranks writeback, which outranks read.
   assign bus.wb_ready = (state_q == IDLE) && !bus.clear_req;
   assign bus.rd_ready = (state_q == IDLE) && !bus.clear_req && !bus.wb_valid;
   assign bus.op_valid = op_valid_q;
   assign bus.op_val1  = op_val1_q;
   assign bus.op_val2  = op_val2_q;

   assign rs_num1         = num1_q;
   assign rs_num2         = num2_q;
   assign rs_setnum       = setnum_q;
   assign rs_setval       = setval_q;
   assign rs_get_enable   = get_q;
   assign rs_set_enable   = set_q;
   assign rs_reset_enable = rst_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: a behavioural register stack answers the DUT's
// commands, and an array of expected register contents predicts every operand.
module tb_reg_access_ctrl;
   localparam int NIB  = 4;
   localparam int WORD = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   reg_access_if #(.NIB_SIZE(NIB), .WORD_SIZE(WORD)) bus ();

   logic [NIB-1:0]  rs_num1, rs_num2, rs_setnum;
   logic [WORD-1:0] rs_setval, rs_out1, rs_out2;
   logic            rs_get_enable, rs_set_enable, rs_reset_enable;

   reg_access_ctrl #(.NIB_SIZE(NIB), .WORD_SIZE(WORD), .REG_STACK_SIZE(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .bus             (bus.slave),
      .rs_num1         (rs_num1),
      .rs_num2         (rs_num2),
      .rs_setnum       (rs_setnum),
      .rs_setval       (rs_setval),
      .rs_get_enable   (rs_get_enable),
      .rs_set_enable   (rs_set_enable),
      .rs_reset_enable (rs_reset_enable),
      .rs_out1         (rs_out1),
      .rs_out2         (rs_out2)
   );

   // Register stack: commands act on the clock edge, read data is registered.
   logic [WORD-1:0] stk [16];
   always @(posedge clk) begin
      if (rs_reset_enable) begin
         for (int i = 0; i < 16; i++) stk[i] <= '0;
      end else if (rs_set_enable) begin
         stk[rs_setnum] <= rs_setval;
      end
      if (rs_get_enable) begin
         rs_out1 <= stk[rs_num1];
         rs_out2 <= stk[rs_num2];
      end
   end

   // Command monitor: counts overlaps, over-long pulses and pulse totals.
   int excl_viol = 0, long_viol = 0, rst_pulses = 0, set_cycles = 0;
   logic prev_get = 1'b0, prev_set = 1'b0, prev_rst = 1'b0;
   always @(negedge clk) begin
      if ((int'(rs_get_enable) + int'(rs_set_enable) + int'(rs_reset_enable)) > 1) excl_viol++;
      if ((rs_get_enable && prev_get) || (rs_set_enable && prev_set) || (rs_reset_enable && prev_rst))
         long_viol++;
      if (rs_reset_enable) rst_pulses++;
      if (rs_set_enable) set_cycles++;
      prev_get = rs_get_enable;
      prev_set = rs_set_enable;
      prev_rst = rs_reset_enable;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
      $fatal(1);
   end

   int errors = 0;
   int checks = 0;
   logic [WORD-1:0] model_regs [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
   endtask

   // Writeback transaction; starts and ends just after a rising edge.
   task automatic wr(input logic [NIB-1:0] n, input logic [WORD-1:0] v);
      int k;
      int sc0;
      bus.wb_num   = n;
      bus.wb_val   = v;
      bus.wb_valid = 1'b1;
      @(negedge clk);
      k = 0;
      while (!bus.wb_ready && k < 50) begin @(negedge clk); k++; end
      chk("wb_accept", {31'd0, bus.wb_ready}, 1);
      sc0 = set_cycles;
      @(posedge clk); #1;
      bus.wb_valid = 1'b0;
      @(negedge clk);
      chk("set_enable", {31'd0, rs_set_enable}, 1);
      chk("set_num", {28'd0, rs_setnum}, {28'd0, n});
      chk("set_val", {16'd0, rs_setval}, {16'd0, v});
      model_regs[n] = v;
      @(posedge clk); #1;
      chk("set_pulse_count", set_cycles - sc0, 1);
   endtask

   // Operand read. hold = cycles op_ready stays low in RESP; kind 1 raises a
   // writeback (pn,pv) during the hold, kind 2 raises clear_req during the hold.
   task automatic rd(input logic [NIB-1:0] a, input logic [NIB-1:0] b, input int hold,
                     input int kind, input logic [NIB-1:0] pn, input logic [WORD-1:0] pv,
                     output logic [WORD-1:0] v1, output logic [WORD-1:0] v2);
      int k;
      int rp0;
      bus.rd_num1  = a;
      bus.rd_num2  = b;
      bus.rd_valid = 1'b1;
      bus.op_ready = 1'b0;
      @(negedge clk);
      k = 0;
      while (!bus.rd_ready && k < 50) begin @(negedge clk); k++; end
      chk("rd_accept", {31'd0, bus.rd_ready}, 1);
      @(posedge clk); #1;
      bus.rd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("op_valid_early", {31'd0, bus.op_valid}, 0);
      end
      @(negedge clk);
      chk("op_valid_latency", {31'd0, bus.op_valid}, 1);
      v1 = bus.op_val1;
      v2 = bus.op_val2;
      rp0 = rst_pulses;
      if (kind == 1) begin
         bus.wb_num   = pn;
         bus.wb_val   = pv;
         bus.wb_valid = 1'b1;
      end else if (kind == 2) begin
         bus.clear_req = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, bus.op_valid}, 1);
         chk("hold_val1", {16'd0, bus.op_val1}, {16'd0, v1});
         chk("hold_val2", {16'd0, bus.op_val2}, {16'd0, v2});
         chk("hold_wb_ready", {31'd0, bus.wb_ready}, 0);
      end
      bus.op_ready = 1'b1;
      @(posedge clk); #1;
      bus.op_ready = 1'b0;
      @(negedge clk);
      chk("op_valid_drop", {31'd0, bus.op_valid}, 0);
      if (kind == 1) begin
         chk("deferred_wb_ready", {31'd0, bus.wb_ready}, 1);
         @(posedge clk); #1;
         bus.wb_valid = 1'b0;
         @(negedge clk);
         chk("deferred_set_num", {28'd0, rs_setnum}, {28'd0, pn});
         chk("deferred_set_val", {16'd0, rs_setval}, {16'd0, pv});
         model_regs[pn] = pv;
      end else if (kind == 2) begin
         chk("clear_deferred", rst_pulses - rp0, 0);
         @(posedge clk); #1;
         bus.clear_req = 1'b0;
         @(negedge clk);
         chk("clear_pulse", {31'd0, rs_reset_enable}, 1);
         model_clear();
      end
      @(posedge clk); #1;
      if (kind == 2) chk("clear_pulse_count", rst_pulses - rp0, 1);
   endtask

   task automatic rdchk(input logic [NIB-1:0] a, input logic [NIB-1:0] b, input int hold);
      logic [WORD-1:0] e1, e2, v1, v2;
      e1 = model_regs[a];
      e2 = model_regs[b];
      rd(a, b, hold, 0, '0, '0, v1, v2);
      chk("op_val1", {16'd0, v1}, {16'd0, e1});
      chk("op_val2", {16'd0, v2}, {16'd0, e2});
   endtask

   task automatic check_reset_outputs();
      chk("rst_get_en", {31'd0, rs_get_enable}, 0);
      chk("rst_set_en", {31'd0, rs_set_enable}, 0);
      chk("rst_reset_en", {31'd0, rs_reset_enable}, 0);
      chk("rst_op_valid", {31'd0, bus.op_valid}, 0);
      chk("rst_wb_ready", {31'd0, bus.wb_ready}, 0);
      chk("rst_rd_ready", {31'd0, bus.rd_ready}, 0);
   endtask

   // Release reset at a falling edge and check the single INIT clear pulse.
   task automatic release_and_init();
      int rp0;
      rp0 = rst_pulses;
      reset_n = 1'b1;
      @(negedge clk);
      chk("init_pulse", {31'd0, rs_reset_enable}, 1);
      chk("init_rd_ready", {31'd0, bus.rd_ready}, 0);
      chk("init_wb_ready", {31'd0, bus.wb_ready}, 0);
      @(negedge clk);
      chk("init_pulse_end", {31'd0, rs_reset_enable}, 0);
      chk("post_init_rd_ready", {31'd0, bus.rd_ready}, 1);
      chk("init_pulse_count", rst_pulses - rp0, 1);
      model_clear();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [WORD-1:0] v1, v2;
      logic [NIB-1:0]  ra, rb;
      logic [WORD-1:0] rv;
      int              rp0;
      bus.clear_req = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_num    = '0;
      bus.wb_val    = '0;
      bus.rd_valid  = 1'b0;
      bus.rd_num1   = '0;
      bus.rd_num2   = '0;
      bus.op_ready  = 1'b0;
      model_clear();

      // Reset state, then INIT and a read of untouched registers.
      repeat (3) @(negedge clk);
      check_reset_outputs();
      release_and_init();
      rdchk(4'd3, 4'd7, 0);

      // Write then read the same register on both operands.
      wr(4'd5, 16'h1234);
      rdchk(4'd5, 4'd5, 0);
      chk("r5_direct", {16'd0, model_regs[5]}, 32'h1234);

      // Simultaneous writeback and read: writeback wins.
      bus.wb_num   = 4'd2;
      bus.wb_val   = 16'h00AA;
      bus.rd_num1  = 4'd2;
      bus.rd_num2  = 4'd1;
      bus.wb_valid = 1'b1;
      bus.rd_valid = 1'b1;
      @(negedge clk);
      chk("both_wb_ready", {31'd0, bus.wb_ready}, 1);
      chk("both_rd_ready", {31'd0, bus.rd_ready}, 0);
      @(posedge clk); #1;
      bus.wb_valid = 1'b0;
      @(negedge clk);
      chk("both_set_en", {31'd0, rs_set_enable}, 1);
      chk("both_rd_ready_set", {31'd0, bus.rd_ready}, 0);
      model_regs[2] = 16'h00AA;
      @(posedge clk); #1;
      rd(4'd2, 4'd1, 0, 0, '0, '0, v1, v2);
      chk("both_op1", {16'd0, v1}, 32'h00AA);
      chk("both_op2", {16'd0, v2}, 32'h0000);

      // Back-pressure in RESP with a stalled writeback.
      rd(4'd2, 4'd5, 5, 1, 4'd9, 16'hBEEF, v1, v2);
      chk("bp_op1", {16'd0, v1}, 32'h00AA);
      chk("bp_op2", {16'd0, v2}, 32'h1234);
      rdchk(4'd9, 4'd2, 0);

      // Clear requested during RESP is deferred to IDLE.
      wr(4'd4, 16'h00FF);
      rd(4'd4, 4'd9, 2, 2, '0, '0, v1, v2);
      chk("clr_op1", {16'd0, v1}, 32'h00FF);
      chk("clr_op2", {16'd0, v2}, 32'hBEEF);
      rdchk(4'd4, 4'd9, 0);

      // Randomised writes and reads against the expected-contents array.
      for (int i = 0; i < 30; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rv = 16'($urandom());
         if ($urandom_range(0, 1) == 1) wr(ra, rv);
         else rdchk(ra, rb, int'($urandom_range(0, 2)));
      end

      // Reset pulsed during WAIT abandons the read.
      wr(4'd6, 16'h5A5A);
      bus.rd_num1  = 4'd6;
      bus.rd_num2  = 4'd6;
      bus.rd_valid = 1'b1;
      @(negedge clk);
      chk("w_rd_accept", {31'd0, bus.rd_ready}, 1);
      @(posedge clk); #1;
      bus.rd_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rp0 = rst_pulses;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abandon_op_valid", {31'd0, bus.op_valid}, 0);
         chk("abandon_no_cmd", {31'd0, rs_get_enable | rs_set_enable | rs_reset_enable}, 0);
      end
      chk("abandon_no_pulse", rst_pulses - rp0, 0);
      release_and_init();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("after_abandon_op_valid", {31'd0, bus.op_valid}, 0);
      end
      @(posedge clk); #1;
      rdchk(4'd6, 4'd5, 0);

      // Held clear_req produces repeated single-cycle clears.
      rp0 = rst_pulses;
      bus.clear_req = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      bus.clear_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("repeated_clears", rst_pulses - rp0, 3);
      model_clear();

      chk("enable_exclusive", excl_viol, 0);
      chk("enable_one_cycle", long_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
